// File: rtl/ffa_pkg.sv
// ffa_pkg: field width, modulus and arbiter FSM states shared by the ffa arbiter
package ffa_pkg;
  localparam int FE_W = 255;
  localparam logic [FE_W-1:0] P = {{247{1'b1}}, 8'hED};
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from last_grant+1
module rr_arbiter import ffa_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant
);
  always_comb begin
    grant = '0;
    for (int i = NREQ; i >= 1; i--)
      if (req[IW'((int'(last_grant) + i) % NREQ)]) begin
        grant = '0;
        grant[IW'((int'(last_grant) + i) % NREQ)] = 1'b1;
      end
  end
endmodule

// File: rtl/ffa_arbiter.sv
// ffa_arbiter: round-robin sharing of one ffa adder; FFA_ARB_TMO_EN adds a WAIT watchdog
module ffa_arbiter import ffa_pkg::*; #(
  parameter int NREQ = 4,
  parameter int TMO_CYCLES = 16,
  localparam int IW = idx_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FE_W-1:0] req_a,
  input  logic [NREQ*FE_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FE_W-1:0]      rsp_data,
  output logic                 busy,
  output logic                 err,
  output logic                 ffa_start,
  output logic [FE_W-1:0]      ffa_a,
  output logic [FE_W-1:0]      ffa_b,
  input  logic                 ffa_done,
  input  logic [FE_W-1:0]      ffa_out
);
  state_t state, nxt;
  logic [IW-1:0] last_grant, idx, pick_idx;
  logic [NREQ-1:0] pick;
  logic err_q, tmo;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req_valid), .last_grant(last_grant), .grant(pick));
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = IW'(i);
  end
`ifdef FFA_ARB_TMO_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst_n || state != WAIT) ? '0 : cnt + 1'b1;
  assign tmo = state == WAIT && !ffa_done && cnt == CW'(TMO_CYCLES - 1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req_valid ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (ffa_done || tmo) ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    ffa_start = state == ISSUE;
    req_ready = (state == IDLE && rst_n) ? pick : '0;
    rsp_valid = state == RESP ? NREQ'(1) << idx : '0;
    err = state == RESP && err_q;
  end
  // operands stay latched from grant until the next grant so the adder can read slices late
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IW'(NREQ - 1);
      idx <= '0;
      ffa_a <= '0;
      ffa_b <= '0;
      rsp_data <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && |req_valid) begin
        idx <= pick_idx;
        ffa_a <= req_a[int'(pick_idx) * FE_W +: FE_W];
        ffa_b <= req_b[int'(pick_idx) * FE_W +: FE_W];
      end
      if (state == WAIT && (ffa_done || tmo)) begin
        rsp_data <= ffa_done ? ffa_out : '0;
        err_q <= !ffa_done;
      end
      if (state == RESP) last_grant <= idx;
    end
  end
endmodule

// File: doc/ffa_arbiter.md
FFA_ARBITER -- requirements
Module: ffa_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters sharing one ffa field adder.
REQ-002 SHALL have parameter TMO_CYCLES, default 16, the WAIT-state watchdog limit (used only with FFA_ARB_TMO_EN).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_a  input  NREQ*255  packed operand A per requester, each < p.
REQ-008 SHALL have port req_b  input  NREQ*255  packed operand B per requester, each < p.
REQ-009 SHALL have port req_ready  output  NREQ  one-cycle pulse: request accepted, operands latched.
REQ-010 SHALL have port rsp_valid  output  NREQ  one-cycle pulse: result for that requester on rsp_data.
REQ-011 SHALL have port rsp_data  output  255  (a+b) mod p for the current response.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port err  output  1  timeout flag, qualified by rsp_valid.
REQ-014 SHALL have port ffa_start  output  1  start pulse to adder.
REQ-015 SHALL have ports ffa_a, ffa_b  output  255  adder operands.
REQ-016 SHALL have port ffa_done  input  1  adder completion pulse.
REQ-017 SHALL have port ffa_out  input  255  adder result, valid while ffa_done=1.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-019 IDLE: on any req_valid, SHALL grant round-robin from (last_grant+1) mod NREQ, latch that requester's operands, pulse req_ready[idx], and go to ISSUE.
REQ-020 ISSUE: SHALL assert ffa_start for exactly one cycle, then go to WAIT.
REQ-021 SHALL hold ffa_a/ffa_b constant from ISSUE through the cycle in which ffa_done is sampled; the adder reads operand slices over several cycles.
REQ-022 WAIT: on ffa_done=1, SHALL register ffa_out into rsp_data in that same cycle and go to RESP (the adder result is valid only alongside done).
REQ-023 RESP: SHALL pulse rsp_valid[idx] for one cycle, set last_grant=idx, and return to IDLE; rsp_data holds until the next capture.
REQ-024 SHALL have nominal latency of ffa_done 5 cycles after the ffa_start cycle, but correctness SHALL NOT depend on that exact count.
REQ-025 SHALL ignore ffa_done in IDLE, ISSUE or RESP.
REQ-026 SHALL keep at most one operation outstanding; the next ffa_start only after the prior done.
REQ-027 Requesters may change operands or drop req_valid after req_ready; the result SHALL use latched values.
REQ-028 SHALL not re-grant the same requester back-to-back while another requester is valid.
REQ-029 SHALL perform no arithmetic; modular reduction is the adder's.

Reset
REQ-030 While rst_n=0 at a clock edge: SHALL set state IDLE, last_grant NREQ-1 (requester 0 wins first), and clear all outputs, rsp_data and latched operands.
REQ-031 Reset mid-operation SHALL abandon the operation with no rsp_valid; integration ties the adder reset to ~rst_n.

Configuration
REQ-032 With FFA_ARB_TMO_EN defined: a WAIT counter SHALL, after TMO_CYCLES cycles without ffa_done, go to RESP with rsp_data=0 and err=1 alongside rsp_valid[idx].
REQ-033 With FFA_ARB_TMO_EN undefined: no counter, err tied 0, WAIT held indefinitely.

Structure
REQ-034 Package ffa_pkg SHALL hold FE_W=255, constant P=2^255-19 and the FSM state enum.
REQ-035 Sub-module rr_arbiter SHALL compute the one-hot round-robin pick from req_valid and last_grant.

Verification
REQ-036 req_valid[0], a=1, b=2 -> req_ready[0] pulse, one ffa_start, rsp_valid[0] with rsp_data=3, err=0.
REQ-037 req_valid[2], a=p-1, b=5 -> rsp_valid[2] with rsp_data=4.
REQ-038 All four requesters held valid continuously -> grant order 0,1,2,3,0; exactly one ffa_start per grant.
REQ-039 Requester 1 changes req_a the cycle after req_ready -> ffa_a stable for the whole operation; result uses the old value.
REQ-040 rst_n low during WAIT -> all outputs 0 next cycle, no rsp_valid; next request served from requester 0.
REQ-041 FFA_ARB_TMO_EN on, ffa_done stuck low -> after 16 WAIT cycles, rsp_valid[idx] with err=1 and rsp_data=0; the following request completes normally.
